// File: rtl/tt_tbuf_seq.sv
`default_nettype none
// ============================================================================
// Module      : tt_tbuf_seq
// Description : Break-before-make enable sequencer for N_CH tristate drivers
//               sharing one net; at most one enable active, with a
//               programmable all-off dead time on every ownership change.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_tbuf_seq #(
    parameter int N_CH        = 4,
    parameter int SEL_W       = $clog2(N_CH),
    parameter int DEAD_CYCLES = 2,
    parameter bit EN_POL      = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [SEL_W-1:0]  req_sel,
    input  logic              req_off,
    output logic              req_ready,
    output logic              req_err,
    output logic [N_CH-1:0]   t,
    output logic [N_CH-1:0]   tx,
    output logic              active_vld,
    output logic [SEL_W-1:0]  active_sel,
    output logic              busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_DEAD  = 2'd2;

    localparam logic [SEL_W:0]  c_n_ch = (SEL_W+1)'(N_CH);
    localparam logic [3:0]      c_dead = 4'(DEAD_CYCLES);
    localparam logic [N_CH-1:0] c_one  = N_CH'(1);

    logic [1:0]       r_state;
    logic [N_CH-1:0]  r_t;
    logic [SEL_W-1:0] r_active_sel;
    logic             r_active_vld;
    logic             r_busy;
    logic             r_req_err;
    logic [3:0]       r_cnt;
    logic [SEL_W-1:0] r_pend_sel;
    logic             r_pend_none;

    logic [1:0]       w_state_nxt;
    logic [N_CH-1:0]  w_t_nxt;
    logic [SEL_W-1:0] w_active_sel_nxt;
    logic             w_req_err_nxt;
    logic [3:0]       w_cnt_nxt;
    logic [SEL_W-1:0] w_pend_sel_nxt;
    logic             w_pend_none_nxt;
    logic             w_accept;
    logic             w_sel_bad;

    assign req_ready = ~rst & (r_state != S_DEAD);
    assign w_accept  = req_valid & req_ready;
    // Only reachable when N_CH is not a power of two.
    assign w_sel_bad = ({1'b0, req_sel} >= c_n_ch);

    always_comb begin
        w_state_nxt      = r_state;
        w_t_nxt          = r_t;
        w_active_sel_nxt = r_active_sel;
        w_req_err_nxt    = 1'b0;
        w_cnt_nxt        = r_cnt;
        w_pend_sel_nxt   = r_pend_sel;
        w_pend_none_nxt  = r_pend_none;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !req_off) begin
                    if (w_sel_bad) begin
                        w_req_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt      = S_DRIVE;
                        w_t_nxt          = c_one << req_sel;
                        w_active_sel_nxt = req_sel;
                    end
                end
            end
            S_DRIVE: begin
                if (w_accept) begin
                    if (req_off) begin
                        w_t_nxt         = '0;
                        w_pend_none_nxt = 1'b1;
                        w_cnt_nxt       = c_dead;
                        w_state_nxt     = S_DEAD;
                    end else if (w_sel_bad) begin
                        w_req_err_nxt = 1'b1;
                    end else if (req_sel != r_active_sel) begin
                        w_t_nxt         = '0;
                        w_pend_sel_nxt  = req_sel;
                        w_pend_none_nxt = 1'b0;
                        w_cnt_nxt       = c_dead;
                        w_state_nxt     = S_DEAD;
                    end
                end
            end
            S_DEAD: begin
                // Counter holds the number of dead cycles left including this one.
                if (r_cnt <= 4'd1) begin
                    w_cnt_nxt = 4'd0;
                    if (r_pend_none) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt      = S_DRIVE;
                        w_t_nxt          = c_one << r_pend_sel;
                        w_active_sel_nxt = r_pend_sel;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_t_nxt     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_t          <= '0;
            r_active_sel <= '0;
            r_active_vld <= 1'b0;
            r_busy       <= 1'b0;
            r_req_err    <= 1'b0;
            r_cnt        <= 4'd0;
            r_pend_sel   <= '0;
            r_pend_none  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_t          <= w_t_nxt;
            r_active_sel <= w_active_sel_nxt;
            r_active_vld <= (w_state_nxt == S_DRIVE);
            r_busy       <= (w_state_nxt == S_DEAD);
            r_req_err    <= w_req_err_nxt;
            r_cnt        <= w_cnt_nxt;
            r_pend_sel   <= w_pend_sel_nxt;
            r_pend_none  <= w_pend_none_nxt;
        end
    end

    assign t          = r_t;
    assign active_sel = r_active_sel;
    assign active_vld = r_active_vld;
    assign busy       = r_busy;
    assign req_err    = r_req_err;

    generate
        if (EN_POL) begin : g_pol_high
            assign tx = r_t;
        end else begin : g_pol_low
            assign tx = ~r_t;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_tt_tbuf_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_tt_tbuf_seq
// Description : Directed and soak bench for tt_tbuf_seq over three
//               parameter sets (N4/D3/active-low, N4/D2/active-high, N3/D1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_tbuf_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: N_CH=4, DEAD_CYCLES=3, active-low cells
    logic       a_req_valid = 1'b0, a_req_off = 1'b0;
    logic [1:0] a_req_sel = '0;
    logic       a_req_ready, a_req_err, a_active_vld, a_busy;
    logic [3:0] a_t, a_tx;
    logic [1:0] a_active_sel;

    tt_tbuf_seq #(.N_CH(4), .DEAD_CYCLES(3), .EN_POL(1'b0)) dut_a (
        .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_sel(a_req_sel),
        .req_off(a_req_off), .req_ready(a_req_ready), .req_err(a_req_err),
        .t(a_t), .tx(a_tx), .active_vld(a_active_vld),
        .active_sel(a_active_sel), .busy(a_busy)
    );

    // Instance B: N_CH=4, DEAD_CYCLES=2, active-high cells
    logic       b_req_valid = 1'b0, b_req_off = 1'b0;
    logic [1:0] b_req_sel = '0;
    logic       b_req_ready, b_req_err, b_active_vld, b_busy;
    logic [3:0] b_t, b_tx;
    logic [1:0] b_active_sel;

    tt_tbuf_seq #(.N_CH(4), .DEAD_CYCLES(2), .EN_POL(1'b1)) dut_b (
        .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_sel(b_req_sel),
        .req_off(b_req_off), .req_ready(b_req_ready), .req_err(b_req_err),
        .t(b_t), .tx(b_tx), .active_vld(b_active_vld),
        .active_sel(b_active_sel), .busy(b_busy)
    );

    // Instance C: N_CH=3 (non power of two), DEAD_CYCLES=1
    logic       c_req_valid = 1'b0, c_req_off = 1'b0;
    logic [1:0] c_req_sel = '0;
    logic       c_req_ready, c_req_err, c_active_vld, c_busy;
    logic [2:0] c_t, c_tx;
    logic [1:0] c_active_sel;

    tt_tbuf_seq #(.N_CH(3), .DEAD_CYCLES(1), .EN_POL(1'b0)) dut_c (
        .clk(clk), .rst(rst), .req_valid(c_req_valid), .req_sel(c_req_sel),
        .req_off(c_req_off), .req_ready(c_req_ready), .req_err(c_req_err),
        .t(c_t), .tx(c_tx), .active_vld(c_active_vld),
        .active_sel(c_active_sel), .busy(c_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Continuous invariants on A: one-hot, polarity map, dead time between owners.
    int zero_run   = 0;
    int last_owner = -1;
    always @(negedge clk) begin
        int own;
        n_checks++;
        if (!$onehot0(a_t)) begin
            n_fail++;
            $display("FAIL onehot_a: t=%b required onehot0", a_t);
        end
        n_checks++;
        if (a_tx !== ~a_t || b_tx !== b_t) begin
            n_fail++;
            $display("FAIL tx_map: a_tx=%b a_t=%b b_tx=%b b_t=%b required a_tx=~a_t b_tx=b_t",
                     a_tx, a_t, b_tx, b_t);
        end
        if (rst) begin
            last_owner = -1;
            zero_run   = 0;
        end else if (a_t == 4'b0000) begin
            zero_run++;
        end else begin
            own = 0;
            for (int i = 0; i < 4; i++) if (a_t[i]) own = i;
            if (last_owner >= 0 && own != last_owner) begin
                n_checks++;
                if (zero_run < 3) begin
                    n_fail++;
                    $display("FAIL dead_time_a: %0d off cycles between owner %0d and %0d, required >= 3",
                             zero_run, last_owner, own);
                end
            end
            last_owner = own;
            zero_run   = 0;
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_checks++;
        if (a_req_ready !== 1'b0) begin n_fail++; $display("FAIL ready_in_rst: got %b required 0", a_req_ready); end
        rst = 1'b0;
        tick();
        n_checks++;
        if (a_t !== 4'b0000 || a_tx !== 4'b1111) begin
            n_fail++; $display("FAIL reset_a_t_tx: t=%b tx=%b required 0000/1111", a_t, a_tx);
        end
        n_checks++;
        if (a_req_ready !== 1'b1 || a_busy !== 1'b0 || a_active_vld !== 1'b0 ||
            a_active_sel !== 2'd0 || a_req_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_a_flags: ready=%b busy=%b vld=%b sel=%0d err=%b required 1/0/0/0/0",
                     a_req_ready, a_busy, a_active_vld, a_active_sel, a_req_err);
        end
        n_checks++;
        if (b_tx !== 4'b0000 || c_tx !== 3'b111) begin
            n_fail++; $display("FAIL reset_bc_tx: b_tx=%b c_tx=%b required 0000/111", b_tx, c_tx);
        end
    endtask

    task automatic test_idle_request();
        a_req_valid = 1'b1; a_req_sel = 2'd2;
        tick();
        a_req_valid = 1'b0;
        n_checks++;
        if (a_t !== 4'b0100 || a_tx !== 4'b1011 || a_active_vld !== 1'b1 || a_active_sel !== 2'd2) begin
            n_fail++;
            $display("FAIL idle_req: t=%b tx=%b vld=%b sel=%0d required 0100/1011/1/2",
                     a_t, a_tx, a_active_vld, a_active_sel);
        end
    endtask

    task automatic test_same_sel();
        a_req_valid = 1'b1; a_req_sel = 2'd2;
        tick();
        a_req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (a_t !== 4'b0100 || a_busy !== 1'b0 || a_req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL same_sel[%0d]: t=%b busy=%b ready=%b required 0100/0/1", i, a_t, a_busy, a_req_ready);
            end
            tick();
        end
    endtask

    task automatic test_switch();
        a_req_valid = 1'b1; a_req_sel = 2'd0;
        tick();
        a_req_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            n_checks++;
            if (a_t !== 4'b0000 || a_busy !== 1'b1 || a_req_ready !== 1'b0 || a_active_vld !== 1'b0) begin
                n_fail++;
                $display("FAIL switch_dead[k+%0d]: t=%b busy=%b ready=%b vld=%b required 0000/1/0/0",
                         i, a_t, a_busy, a_req_ready, a_active_vld);
            end
            tick();
        end
        n_checks++;
        if (a_t !== 4'b0001 || a_busy !== 1'b0 || a_active_sel !== 2'd0 ||
            a_active_vld !== 1'b1 || a_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL switch_done: t=%b busy=%b sel=%0d vld=%b ready=%b required 0001/0/0/1/1",
                     a_t, a_busy, a_active_sel, a_active_vld, a_req_ready);
        end
    endtask

    task automatic test_reset_mid_dead();
        a_req_valid = 1'b1; a_req_sel = 2'd1;
        tick();
        a_req_valid = 1'b0;
        rst = 1'b1;
        tick();
        n_checks++;
        if (a_t !== 4'b0000 || a_busy !== 1'b0 || a_active_vld !== 1'b0 || a_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_dead: t=%b busy=%b vld=%b ready=%b required 0000/0/0/0",
                     a_t, a_busy, a_active_vld, a_req_ready);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (a_req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_dead_ready: got %b required 1", a_req_ready); end
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (a_t !== 4'b0000 || a_active_vld !== 1'b0) begin
                n_fail++; $display("FAIL pending_discarded[%0d]: t=%b vld=%b required 0000/0", i, a_t, a_active_vld);
            end
        end
    endtask

    task automatic test_release();
        b_req_valid = 1'b1; b_req_off = 1'b1;
        tick();
        n_checks++;
        if (b_t !== 4'b0000 || b_busy !== 1'b0 || b_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL idle_off: t=%b busy=%b ready=%b required 0000/0/1", b_t, b_busy, b_req_ready);
        end
        b_req_off = 1'b0; b_req_sel = 2'd1;
        tick();
        n_checks++;
        if (b_t !== 4'b0010 || b_tx !== 4'b0010) begin
            n_fail++; $display("FAIL b_owner1: t=%b tx=%b required 0010/0010", b_t, b_tx);
        end
        b_req_off = 1'b1; b_req_sel = 2'd2;
        tick();
        b_req_valid = 1'b0; b_req_off = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            n_checks++;
            if (b_t !== 4'b0000 || b_busy !== 1'b1 || b_req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL release_dead[k+%0d]: t=%b busy=%b ready=%b required 0000/1/0", i, b_t, b_busy, b_req_ready);
            end
            tick();
        end
        n_checks++;
        if (b_t !== 4'b0000 || b_busy !== 1'b0 || b_active_vld !== 1'b0 || b_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release_idle: t=%b busy=%b vld=%b ready=%b required 0000/0/0/1",
                     b_t, b_busy, b_active_vld, b_req_ready);
        end
        b_req_valid = 1'b1; b_req_sel = 2'd3;
        tick();
        b_req_valid = 1'b0;
        n_checks++;
        if (b_t !== 4'b1000 || b_tx !== 4'b1000 || b_active_sel !== 2'd3 || b_active_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL after_release_sel3: t=%b tx=%b sel=%0d vld=%b required 1000/1000/3/1",
                     b_t, b_tx, b_active_sel, b_active_vld);
        end
    endtask

    task automatic test_invalid_sel();
        c_req_valid = 1'b1; c_req_sel = 2'd3;
        tick();
        c_req_valid = 1'b0;
        n_checks++;
        if (c_req_err !== 1'b1 || c_t !== 3'b000 || c_active_vld !== 1'b0 || c_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_bad_sel: err=%b t=%b vld=%b busy=%b required 1/000/0/0", c_req_err, c_t, c_active_vld, c_busy);
        end
        tick();
        n_checks++;
        if (c_req_err !== 1'b0) begin n_fail++; $display("FAIL err_pulse_len: err=%b required 0", c_req_err); end
        c_req_valid = 1'b1; c_req_sel = 2'd2;
        tick();
        c_req_sel = 2'd3;
        tick();
        c_req_valid = 1'b0;
        n_checks++;
        if (c_req_err !== 1'b1 || c_t !== 3'b100 || c_active_sel !== 2'd2 || c_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drive_bad_sel: err=%b t=%b sel=%0d busy=%b required 1/100/2/0", c_req_err, c_t, c_active_sel, c_busy);
        end
        tick();
        n_checks++;
        if (c_req_err !== 1'b0 || c_t !== 3'b100) begin
            n_fail++; $display("FAIL drive_bad_sel_after: err=%b t=%b required 0/100", c_req_err, c_t);
        end
        c_req_valid = 1'b1; c_req_sel = 2'd0;
        tick();
        c_req_valid = 1'b0;
        n_checks++;
        if (c_t !== 3'b000 || c_busy !== 1'b1) begin
            n_fail++; $display("FAIL dead1_gap: t=%b busy=%b required 000/1", c_t, c_busy);
        end
        tick();
        n_checks++;
        if (c_t !== 3'b001 || c_tx !== 3'b110 || c_busy !== 1'b0) begin
            n_fail++; $display("FAIL dead1_done: t=%b tx=%b busy=%b required 001/110/0", c_t, c_tx, c_busy);
        end
    endtask

    task automatic test_soak();
        logic acc;
        for (int i = 0; i < 400; i++) begin
            if (!a_req_valid && $urandom_range(0, 2) == 0) begin
                a_req_valid = 1'b1;
                a_req_sel   = 2'($urandom_range(0, 3));
                a_req_off   = ($urandom_range(0, 4) == 0);
            end
            acc = a_req_valid & a_req_ready;
            tick();
            if (acc) begin
                a_req_valid = 1'b0;
                a_req_off   = 1'b0;
            end
        end
        a_req_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_idle_request();
        test_same_sel();
        test_switch();
        test_reset_mid_dead();
        test_release();
        test_invalid_sel();
        test_soak();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tt_tbuf_seq.md
# tt_tbuf_seq

Parametrised tristate-enable sequencer for a shared output spine. It drives the enables of `N_CH` tristate buffers that share one net, and guarantees at most one enable is active at any time. Every ownership change passes through a programmable all-off dead time (break-before-make). Enables are presented in the polarity the target cell library's tristate primitive expects, so the block can sit directly in front of the per-library buffer cells in the mux output path.

## Interface

Parameters:
- `N_CH`, 4: number of tristate drivers sharing the net; 2..16.
- `SEL_W`, `$clog2(N_CH)`: width of the channel select.
- `DEAD_CYCLES`, 2: all-off cycles inserted on every ownership change or release; 1..15.
- `EN_POL`, 0: cell enable polarity. 1 = active-high enable. 0 = active-low enable (tx = ~t).

Ports:
- `clk`  in  1: single clock; all state on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: request present.
- `req_sel`  in  SEL_W: channel to hand the net to.
- `req_off`  in  1: with `req_valid`, release the net (no owner); `req_sel` ignored.
- `req_ready`  out  1: request accepted on edge when `req_valid & req_ready`.
- `req_err`  out  1: one-cycle pulse, accepted request had `req_sel >= N_CH`.
- `t`  out  N_CH: logical enables, active-high, one-hot or zero.
- `tx`  out  N_CH: cell-polarity enables; `tx = EN_POL ? t : ~t`, bitwise.
- `active_vld`  out  1: a channel currently drives (state DRIVE).
- `active_sel`  out  SEL_W: current owner; valid when `active_vld`.
- `busy`  out  1: state DEAD.

## Operation

- States: IDLE (no owner), DRIVE (one owner), DEAD (all off, counting).
- Reset: state IDLE, `t` = 0, `tx` = all-deasserted (`{N_CH{~EN_POL}}`), `active_vld` = 0, `active_sel` = 0, `busy` = 0, `req_err` = 0, dead counter = 0.
- `req_ready` = 1 in IDLE and DRIVE, 0 in DEAD and while `rst` is high.
- IDLE, accept valid sel: go DRIVE, set `t[sel]`, `active_sel` = sel.
- IDLE, accept `req_off`: no-op, stay IDLE.
- DRIVE, accept same sel and not `req_off`: no-op, `t` unchanged, no glitch.
- DRIVE, accept different valid sel: clear `t`, latch pending sel, load counter to `DEAD_CYCLES`, go DEAD.
- DRIVE, accept `req_off`: clear `t`, mark pending = none, load counter, go DEAD.
- DEAD: decrement each cycle. On the last dead cycle, go DRIVE with the pending sel, or go IDLE if pending = none.
- Invalid sel (`>= N_CH`, only possible when `N_CH` is not a power of two): request is accepted, state and outputs are unchanged, `req_err` pulses on the next cycle.
- Invariant: `$onehot0(t)` every cycle, including through reset.
- Invariant: between any two different owners, `t` == 0 for at least `DEAD_CYCLES` consecutive cycles.

## Timing

- All outputs are registered. `tx` is a pure polarity map of the registered `t`, with no extra flop.
- IDLE accept at edge k: `t[sel]` is high from cycle k+1.
- DRIVE switch accept at edge k:
  - `t` = 0 for cycles k+1 .. k+DEAD_CYCLES.
  - `t[new]` is high from cycle k+DEAD_CYCLES+1.
  - `busy` is high exactly for cycles k+1 .. k+DEAD_CYCLES.
- DRIVE release at edge k: `t` = 0 from k+1. State is IDLE and `req_ready` = 1 from cycle k+DEAD_CYCLES+1.
- Requests presented during DEAD are not accepted. The requester must hold `req_valid`/`req_sel`/`req_off` stable until ready.
- `active_vld`/`active_sel` update in the same cycle as `t`.
- `rst` asserted in any state, including mid-DEAD: at the next edge all outputs go to reset values and the pending request is discarded. No dead time is inserted after reset, because `t` is already 0.

## Test plan

- Reset, then `EN_POL`=0, `N_CH`=4: `tx` = 4'b1111, `t` = 0, `req_ready` = 1 one cycle after `rst` falls.
- IDLE, request sel=2 at edge k: `t` = 4'b0100 at k+1, `active_sel` = 2, `active_vld` = 1. Re-request sel=2: no change, no glitch.
- Owner 2, `DEAD_CYCLES`=3, request sel=0 at edge k: `t` = 0 and `busy` = 1 for k+1..k+3, `req_ready` = 0 during DEAD, `t` = 4'b0001 at k+4.
- Owner 1, `req_off` at edge k with `DEAD_CYCLES`=2: `t` = 0 from k+1, IDLE with `active_vld` = 0 at k+3. A later sel=3 request drives `t` = 4'b1000 one cycle after accept.
- `N_CH`=3, request sel=3: accepted, `req_err` = 1 for one cycle, `t` unchanged.
- Owner 0, switch to 1, `rst` pulsed mid-DEAD: `t` = 0, IDLE, pending discarded, channel 1 never enabled. Random-request soak checks the one-hot and dead-time invariants throughout.
